turbo_deframer_checker: RTL and testbench



---
 rtl/turbo_pkg.sv | 36 +++
 rtl/turbo_deframer_checker_if.sv | 26 ++
 rtl/rsc_parity_check.sv | 33 +++
 rtl/turbo_deframer_checker.sv | 117 +++++++++++
 tb/tb_turbo_deframer_checker.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/turbo_pkg.sv
// rtl/turbo_pkg.sv - shared turbo beat layout and RSC step function
package turbo_pkg;

   localparam int TAIL_BEATS_DEF = 2;
   localparam int BEAT_W         = 6;

   // Coded beat layout {x_k, z_k, z'_k, x_k+1, z_k+1, z'_k+1}
   localparam int X0_BIT  = 5;
   localparam int Z0_BIT  = 4;
   localparam int ZI0_BIT = 3;
   localparam int X1_BIT  = 2;
   localparam int Z1_BIT  = 1;
   localparam int ZI1_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_STREAM
   } frame_state_t;

   typedef struct packed {
      logic [2:0] s_next;
      logic       z;
   } rsc_step_t;

   // LTE constituent encoder: feedback 1+D^2+D^3, parity 1+D+D^3
   function automatic rsc_step_t rsc_step(input logic [2:0] s, input logic x);
      rsc_step_t r;
      logic      a;
      a        = x ^ s[1] ^ s[2];
      r.z      = a ^ s[0] ^ s[2];
      r.s_next = {s[1], s[0], a};
      return r;
   endfunction

endpackage

// File: rtl/turbo_deframer_checker_if.sv
// rtl/turbo_deframer_checker_if.sv - coded-in / systematic-out handshake bundle
interface turbo_deframer_checker_if;
   import turbo_pkg::*;

   logic              i_valid;
   logic              i_bof;
   logic              i_eof;
   logic [BEAT_W-1:0] i_data;
   logic              o_ready;
   logic              o_valid;
   logic              o_bof;
   logic              o_eof;
   logic [1:0]        o_data;
   logic              i_ready;

   modport master (
      output i_valid, i_bof, i_eof, i_data, i_ready,
      input  o_ready, o_valid, o_bof, o_eof, o_data
   );

   modport slave (
      input  i_valid, i_bof, i_eof, i_data, i_ready,
      output o_ready, o_valid, o_bof, o_eof, o_data
   );

endinterface

// File: rtl/rsc_parity_check.sv
// rtl/rsc_parity_check.sv - two-step RSC re-encoder flagging parity mismatch
module rsc_parity_check
   import turbo_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clear,
   input  logic       i_step,
   input  logic [1:0] i_x,
   input  logic [1:0] i_z,
   output logic       o_mismatch
);

   logic [2:0] state;
   rsc_step_t  step_hi;
   rsc_step_t  step_lo;

   // Bit 1 is earlier in time, so it is stepped first
   always_comb begin
      step_hi    = rsc_step(state, i_x[1]);
      step_lo    = rsc_step(step_hi.s_next, i_x[0]);
      o_mismatch = i_step & ((step_hi.z ^ i_z[1]) | (step_lo.z ^ i_z[0]));
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         state <= '0;
      end else if (i_step) begin
         state <= step_lo.s_next;
      end
   end

endmodule

// File: rtl/turbo_deframer_checker.sv
// rtl/turbo_deframer_checker.sv - strips tail beats, forwards systematic bits, checks parity
module turbo_deframer_checker
   import turbo_pkg::*;
#(
   parameter int TAIL_BEATS = TAIL_BEATS_DEF,
   parameter int ERR_W      = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   turbo_deframer_checker_if.slave  bus,
   output logic                     o_frame_done,
   output logic                     o_parity_err,
   output logic                     o_format_err,
   output logic [ERR_W-1:0]         o_err_count
);

   localparam int                CNT_W     = $clog2(TAIL_BEATS + 1);
   localparam logic [CNT_W-1:0]  LAST_FILL = CNT_W'(TAIL_BEATS - 1);

   frame_state_t      state;
   logic [BEAT_W-1:0] dline [TAIL_BEATS];
   logic [CNT_W-1:0]  fill_cnt;
   logic              first_out;
   logic              frame_err;
   logic              accept;
   logic              push_out;
   logic              mismatch;
   logic              err_now;

   assign bus.o_ready = ~bus.o_valid | bus.i_ready;
   assign accept      = bus.i_valid & bus.o_ready;
   assign push_out    = accept & ~bus.i_bof & (state == ST_STREAM);
   assign err_now     = frame_err | mismatch;

   // dline[TAIL_BEATS-1] is the oldest entry once the line is full
   rsc_parity_check u_rsc (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_clear    (accept & bus.i_bof),
      .i_step     (push_out),
      .i_x        ({dline[TAIL_BEATS-1][X0_BIT], dline[TAIL_BEATS-1][X1_BIT]}),
      .i_z        ({dline[TAIL_BEATS-1][Z0_BIT], dline[TAIL_BEATS-1][Z1_BIT]}),
      .o_mismatch (mismatch)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         fill_cnt     <= '0;
         first_out    <= 1'b0;
         frame_err    <= 1'b0;
         bus.o_valid  <= 1'b0;
         bus.o_bof    <= 1'b0;
         bus.o_eof    <= 1'b0;
         bus.o_data   <= '0;
         o_frame_done <= 1'b0;
         o_parity_err <= 1'b0;
         o_format_err <= 1'b0;
         o_err_count  <= '0;
         for (int i = 0; i < TAIL_BEATS; i++) dline[i] <= '0;
      end else begin
         o_frame_done <= 1'b0;
         o_parity_err <= 1'b0;
         o_format_err <= 1'b0;
         if (bus.o_valid && bus.i_ready) bus.o_valid <= 1'b0;

         if (accept) begin
            for (int i = TAIL_BEATS - 1; i > 0; i--) dline[i] <= dline[i-1];
            dline[0] <= bus.i_data;

            if (bus.i_bof) begin
               // Aborting an open frame and a 1-beat frame share one pulse
               o_format_err <= (state != ST_IDLE) | bus.i_eof;
               first_out    <= 1'b1;
               frame_err    <= 1'b0;
               fill_cnt     <= CNT_W'(1);
               if (bus.i_eof)           state <= ST_IDLE;
               else if (TAIL_BEATS == 1) state <= ST_STREAM;
               else                      state <= ST_FILL;
            end else begin
               case (state)
                  ST_IDLE: begin
                     o_format_err <= 1'b1;
                  end
                  ST_FILL: begin
                     if (bus.i_eof) begin
                        o_format_err <= 1'b1;
                        state        <= ST_IDLE;
                     end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == LAST_FILL) state <= ST_STREAM;
                     end
                  end
                  ST_STREAM: begin
                     bus.o_valid <= 1'b1;
                     bus.o_data  <= {dline[TAIL_BEATS-1][X0_BIT], dline[TAIL_BEATS-1][X1_BIT]};
                     bus.o_bof   <= first_out;
                     bus.o_eof   <= bus.i_eof;
                     first_out   <= 1'b0;
                     if (bus.i_eof) begin
                        state        <= ST_IDLE;
                        frame_err    <= 1'b0;
                        o_frame_done <= 1'b1;
                        o_parity_err <= err_now;
                        if (err_now && !(&o_err_count)) o_err_count <= o_err_count + 1'b1;
                     end else begin
                        frame_err <= err_now;
                     end
                  end
                  default: state <= ST_IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_turbo_deframer_checker.sv
// tb/tb_turbo_deframer_checker.sv - scoreboard bench for turbo_deframer_checker
module tb_turbo_deframer_checker;
   import turbo_pkg::*;

   localparam int TB_TAIL  = 2;
   localparam int TB_ERR_W = 8;

   typedef struct packed { logic [1:0] d; logic bof; logic eof; } exp_beat_t;
   typedef struct packed { logic perr; logic [TB_ERR_W-1:0] cnt; } exp_done_t;

   logic clk = 1'b0;
   logic rst;
   logic frame_done, parity_err, format_err;
   logic [TB_ERR_W-1:0] err_count;

   always #5 clk = ~clk;

   turbo_deframer_checker_if bus();

   turbo_deframer_checker #(.TAIL_BEATS(TB_TAIL), .ERR_W(TB_ERR_W)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .bus          (bus),
      .o_frame_done (frame_done),
      .o_parity_err (parity_err),
      .o_format_err (format_err),
      .o_err_count  (err_count)
   );

   exp_beat_t exp_q[$];
   exp_done_t done_q[$];
   exp_beat_t mon_e;
   exp_done_t mon_d;
   int checks = 0;
   int failures = 0;
   int fmt_seen = 0;
   int fmt_exp = 0;
   int ready_mode = 0;
   logic [TB_ERR_W-1:0] exp_count = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Encoder model: regs = {D^3, D^2, D}
   function automatic logic [3:0] enc_bit(input logic [2:0] regs, input logic x);
      logic fb, z;
      fb = x ^ regs[1] ^ regs[2];
      z  = fb ^ regs[0] ^ regs[2];
      return {regs[1], regs[0], fb, z};
   endfunction

   initial begin
      bus.i_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       bus.i_ready = 1'b1;
            1:       bus.i_ready = 1'($urandom_range(0, 1));
            default: bus.i_ready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) check_eq("unexp_beat", bus.o_valid, 0);
            else begin
               mon_e = exp_q.pop_front();
               check_eq("beat_data", bus.o_data, mon_e.d);
               check_eq("beat_bof", bus.o_bof, mon_e.bof);
               check_eq("beat_eof", bus.o_eof, mon_e.eof);
            end
         end
         if (frame_done) begin
            if (done_q.size() == 0) check_eq("unexp_done", frame_done, 0);
            else begin
               mon_d = done_q.pop_front();
               check_eq("parity_err", parity_err, mon_d.perr);
               check_eq("err_count", err_count, mon_d.cnt);
               check_eq("done_with_eof", bus.o_valid & bus.o_eof, 1);
            end
         end
         if (format_err) fmt_seen++;
      end
   end

   task automatic push_beat(input logic [1:0] d, input logic bof, input logic eof);
      exp_q.push_back('{d: d, bof: bof, eof: eof});
   endtask

   task automatic push_done(input logic perr);
      if (perr && exp_count != '1) exp_count++;
      done_q.push_back('{perr: perr, cnt: exp_count});
   endtask

   task automatic send_beat(input logic bof, input logic eof, input logic [5:0] d);
      int n;
      n = 0;
      bus.i_valid = 1'b1;
      bus.i_bof   = bof;
      bus.i_eof   = eof;
      bus.i_data  = d;
      @(negedge clk);
      while (!bus.o_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check_eq("send_ready", bus.o_ready, 1);
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      bus.i_bof   = 1'b0;
      bus.i_eof   = 1'b0;
   endtask

   task automatic send_tails();
      for (int t = 0; t < TB_TAIL; t++) send_beat(1'b0, t == TB_TAIL - 1, 6'($urandom));
   endtask

   task automatic send_model_frame(input int nd, input int flip_beat);
      logic [2:0] regs;
      logic [3:0] r1, r2;
      logic x1, x0;
      logic [5:0] d;
      regs = '0;
      for (int i = 0; i < nd; i++) begin
         x1   = 1'($urandom_range(0, 1));
         x0   = 1'($urandom_range(0, 1));
         r1   = enc_bit(regs, x1);
         r2   = enc_bit(r1[3:1], x0);
         regs = r2[3:1];
         d    = {x1, r1[0], 1'($urandom), x0, r2[0], 1'($urandom)};
         if (i == flip_beat) d[Z0_BIT] = ~d[Z0_BIT];
         push_beat({x1, x0}, i == 0, i == nd - 1);
         if (i == nd - 1) push_done(flip_beat >= 0);
         send_beat(i == 0, 1'b0, d);
      end
      send_tails();
   endtask

   task automatic send_bad_short();
      push_beat(2'b10, 1'b1, 1'b1);
      push_done(1'b1);
      send_beat(1'b1, 1'b0, 6'b100010);
      send_tails();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, exp_q.size() + done_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_fmt(input string tag);
      repeat (3) @(posedge clk);
      #1;
      check_eq(tag, fmt_seen, fmt_exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_bof   = 1'b0;
      bus.i_eof   = 1'b0;
      bus.i_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", bus.o_valid, 0);
      check_eq("rst_ready", bus.o_ready, 1);
      check_eq("rst_data", bus.o_data, 0);
      check_eq("rst_done", frame_done, 0);
      check_eq("rst_fmt", format_err, 0);
      check_eq("rst_count", err_count, 0);
      rst = 1'b0;

      // Zero-state reference frame
      push_beat(2'b10, 1'b1, 1'b0);
      push_beat(2'b11, 1'b0, 1'b1);
      push_done(1'b0);
      send_beat(1'b1, 1'b0, 6'b110010);
      send_beat(1'b0, 1'b0, 6'b100110);
      send_beat(1'b0, 1'b0, 6'b000000);
      send_beat(1'b0, 1'b1, 6'b111111);
      drain("drain_ref");

      // Same frame with z_k of beat 0 flipped
      push_beat(2'b10, 1'b1, 1'b0);
      push_beat(2'b11, 1'b0, 1'b1);
      push_done(1'b1);
      send_beat(1'b1, 1'b0, 6'b100010);
      send_beat(1'b0, 1'b0, 6'b100110);
      send_beat(1'b0, 1'b0, 6'b010101);
      send_beat(1'b0, 1'b1, 6'b101010);
      drain("drain_bad");
      check_eq("count_after_bad", err_count, 1);

      // Long loopback under random back-pressure
      ready_mode = 1;
      send_model_frame(56, -1);
      drain("drain_loop");
      ready_mode = 0;
      send_model_frame(5, 3);
      drain("drain_bad_mid");

      // Frame of TAIL_BEATS beats only
      send_beat(1'b1, 1'b0, 6'h2d);
      send_beat(1'b0, 1'b1, 6'h13);
      fmt_exp++;
      check_fmt("fmt_short");

      // Single beat with bof and eof
      send_beat(1'b1, 1'b1, 6'h3f);
      fmt_exp++;
      check_fmt("fmt_one_beat");

      // Stray beat outside a frame
      send_beat(1'b0, 1'b0, 6'h21);
      fmt_exp++;
      check_fmt("fmt_stray");

      // bof on the third beat aborts the open frame
      send_beat(1'b1, 1'b0, 6'h0c);
      send_beat(1'b0, 1'b0, 6'h33);
      fmt_exp++;
      send_model_frame(2, -1);
      drain("drain_abort");
      check_eq("fmt_abort", fmt_seen, fmt_exp);

      // Back-to-back frames, then drive the counter into saturation
      send_model_frame(3, -1);
      send_model_frame(2, 0);
      while (exp_count != '1) send_bad_short();
      drain("drain_sat");
      check_eq("count_sat", err_count, 8'hff);
      send_bad_short();
      drain("drain_sat2");
      check_eq("count_hold", err_count, 8'hff);

      // Reset in the middle of a frame with output stalled
      ready_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      send_beat(1'b1, 1'b0, 6'b110010);
      send_beat(1'b0, 1'b0, 6'b100110);
      send_beat(1'b0, 1'b0, 6'b000000);
      check_eq("pre_rst_valid", bus.o_valid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("mid_rst_valid", bus.o_valid, 0);
      check_eq("mid_rst_bof", bus.o_bof, 0);
      check_eq("mid_rst_eof", bus.o_eof, 0);
      check_eq("mid_rst_data", bus.o_data, 0);
      check_eq("mid_rst_done", frame_done, 0);
      check_eq("mid_rst_perr", parity_err, 0);
      check_eq("mid_rst_fmt", format_err, 0);
      check_eq("mid_rst_count", err_count, 0);
      rst = 1'b0;
      ready_mode = 0;
      exp_count = '0;
      @(posedge clk); #1;

      // Buffer and RSC state restart cleanly after reset
      push_beat(2'b10, 1'b1, 1'b0);
      push_beat(2'b11, 1'b0, 1'b1);
      push_done(1'b0);
      send_beat(1'b1, 1'b0, 6'b110010);
      send_beat(1'b0, 1'b0, 6'b100110);
      send_tails();
      drain("drain_post_rst");
      check_eq("fmt_final", fmt_seen, fmt_exp);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
